// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and baud divisor helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  // Rounded clocks-per-bit for a given clock frequency and baud rate.
  function automatic int clkdiv(input int freq, input int baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, glitch rejection, framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic                 rx_s;
  state_t               state, state_n;
  logic [CW-1:0]        ccnt, ccnt_n;
  logic [2:0]           bcnt, bcnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 byte_done;
  logic                 stop_bad;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ccnt  <= '0;
      bcnt  <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      ccnt  <= ccnt_n;
      bcnt  <= bcnt_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    ccnt_n    = ccnt;
    bcnt_n    = bcnt;
    shift_n   = shift;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        ccnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        // Half-bit check: a start bit that is no longer low was a glitch.
        if (ccnt == HALF_LAST) begin
          ccnt_n  = '0;
          bcnt_n  = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          ccnt_n = ccnt + 1'b1;
        end
      end
      DATA: begin
        if (ccnt == BIT_LAST) begin
          ccnt_n  = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          if (bcnt == 3'd7) begin
            bcnt_n  = '0;
            state_n = STOP;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end else begin
          ccnt_n = ccnt + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid-stop lets an immediately following start bit be caught.
        if (ccnt == BIT_LAST) begin
          ccnt_n = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_n   = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = BREAK;
          end
        end else begin
          ccnt_n = ccnt + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register: load when empty or being drained this edge, otherwise drop and flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= byte_done && valid && !ready;
      if (byte_done && (!valid || ready)) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive front end for machine1: converts the asynchronous `rx` pin into bytes on a valid/ready interface.
- The machine1 core consumes these bytes; the block sits directly between the board pin and the core.
- Format is 8N1, LSB first, idle-high line.
- Uses a fixed clocks-per-bit counter with mid-bit sampling, start-bit glitch rejection, framing-error and overrun reporting.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200); must be >= 4; the bench uses 16.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line, asynchronous to clk, idle high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  a byte is held in data.
- ready  input  1  consumer accepts data when valid&&ready on a clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte completed while the holding register was still full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, any state):
  - synchronizer flops = 1, FSM = IDLE, bit counter = 0, clock counter = 0.
  - data = 8'h00, valid = 0, frame_err = 0, overrun = 0, busy = 0.
  - Reset mid-frame abandons the frame. After release, the rest of the frame may be misread as a new start; this is accepted, and no output occurs before a full frame.
- Synchronizer: two flops on rx give rx_s. All FSM decisions use rx_s only (2-cycle input latency).
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s==0, go to START with ccnt=0.
  - START: when ccnt==CLKS_PER_BIT/2-1, sample rx_s.
    - 0: go to DATA, ccnt=0, bcnt=0.
    - 1: glitch; return to IDLE with no output.
  - DATA: when ccnt==CLKS_PER_BIT-1, sample rx_s into shift[7] and shift right; ccnt=0, bcnt++.
    - After the 8th sample (bcnt==7), go to STOP.
  - STOP: when ccnt==CLKS_PER_BIT-1, sample rx_s.
    - 1: byte complete; go to IDLE.
    - 0: frame_err pulses for 1 cycle, byte discarded; go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE (no re-trigger during a held-low break).
- Holding register, evaluated on the byte-complete cycle:
  - Empty (valid==0), or valid&&ready this cycle: data<=shift, valid<=1 on the next edge.
  - Full and not accepted: overrun pulses for 1 cycle. The old data and valid are retained; the new byte is dropped.
- Handshake:
  - valid falls the edge after valid&&ready unless a new byte loads the same edge.
  - valid never falls without ready.
  - data does not change while valid=1 except by the simultaneous accept-and-load case.
- Latency: valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge. The bench checks within ±1 cycle.
- Back-to-back frames: the FSM returns to IDLE at the mid-stop-bit sample, so a start bit immediately following the stop bit is caught.
- Counters:
  - ccnt width = $clog2(CLKS_PER_BIT); bcnt = 3 bits.
  - The counters never wrap outside the state-defined terminal counts.
- busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK}.
  - DATA_BITS = 8.
  - function clkdiv(freq, baud) for deriving CLKS_PER_BIT; reused by the later uart_tx.
- One sub-module: sync_2ff (parameterised reset value, here 1), instanced for rx.

Test Plan (CLKS_PER_BIT=16):
- Reset then send 8'hA5 with ready=1:
  - valid rises at 2+8+144+1=155 cycles (±1) after the start edge, data=8'hA5.
  - valid drops the next edge; frame_err=0.
- Glitch: rx low for 5 cycles then high:
  - FSM returns to IDLE after the half-bit check; no valid, no frame_err; busy low again by cycle 11.
- Send 8'h3C with stop bit forced low for 40 cycles:
  - frame_err one-cycle pulse, valid stays 0.
  - No new start detected until rx returns high.
- ready=0, send 8'h11 then 8'h22 back-to-back:
  - valid=1 with data=8'h11.
  - overrun pulses once at the end of the second frame; data stays 8'h11.
- ready=1, send 8'h00, 8'hFF, 8'h80 with no idle gaps:
  - three valid pulses with the matching data in order; overrun=0.
- Assert rst during bit 4 of a frame:
  - all outputs go to reset values immediately (async).
  - A clean frame 8'h5A sent after release is received correctly.
